// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture front end.
package cam_pkg;

   localparam int unsigned ADDR_W = 22;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      CAPTURE = 2'd2
   } cam_state_e;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cam_frame_writer_if.sv
// Write-port bundle between the frame writer (master) and the SDRAM controller port (slave).
interface cam_frame_writer_if;
   import cam_pkg::*;

   logic [15:0]       WR_DATA;
   logic              WR;
   logic              WR_LOAD;
   logic [ADDR_W-1:0] WR_ADDR;
   logic [8:0]        WR_LENGTH;
   logic              WR_FULL;

   modport master (
      output WR_DATA, WR, WR_LOAD, WR_ADDR, WR_LENGTH,
      input  WR_FULL
   );

   modport slave (
      input  WR_DATA, WR, WR_LOAD, WR_ADDR, WR_LENGTH,
      output WR_FULL
   );
endinterface

// File: rtl/cam_byte_packer.sv
// Pairs byte-serial pixel data into 16-bit words: first byte latched as high byte,
// second byte completes the word and raises word_vld for that cycle.
module cam_byte_packer (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_in,
   output logic        word_vld,
   output logic [15:0] word
);

   logic       phase_q, phase_d;
   logic [7:0] hi_q, hi_d;

   // Phase toggle and high-byte latch; clr drops any half-assembled word.
   always_comb begin
      phase_d  = phase_q;
      hi_d     = hi_q;
      word_vld = 1'b0;
      if (clr) begin
         phase_d = 1'b0;
      end else if (byte_vld) begin
         if (!phase_q) begin
            hi_d    = byte_in;
            phase_d = 1'b1;
         end else begin
            word_vld = 1'b1;
            phase_d  = 1'b0;
         end
      end else begin
         phase_d = phase_q;
      end
   end

   // Packer state registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         phase_q <= 1'b0;
         hi_q    <= 8'h00;
      end else begin
         phase_q <= phase_d;
         hi_q    <= hi_d;
      end
   end

   assign word = {hi_q, byte_in};

endmodule

// File: rtl/cam_frame_writer.sv
// Camera-to-SDRAM write-port capture: crops to H_ACTIVE x V_ACTIVE, one WR per pixel.
// Define CAM_TEST_PATTERN_EN to add PATTERN_SEL and an 8-bar colour test pattern.
module cam_frame_writer
   import cam_pkg::*;
#(
   parameter int unsigned       H_ACTIVE  = 640,
   parameter int unsigned       V_ACTIVE  = 480,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 22'h000000,
   parameter int unsigned       BURST_LEN = 128
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        EN,
   input  logic        CAM_VSYNC,
   input  logic        CAM_HREF,
   input  logic [7:0]  CAM_D,
`ifdef CAM_TEST_PATTERN_EN
   input  logic        PATTERN_SEL,
`endif
   cam_frame_writer_if.master wr_port,
   output logic        FRAME_DONE,
   output logic        OVERFLOW,
   output logic [15:0] FRAME_CNT
);

   localparam int unsigned XW = $clog2(H_ACTIVE + 1);
   localparam int unsigned YW = $clog2(V_ACTIVE + 1);
   localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);

   logic        vsync_q, href_q, vsync_prev_q, href_prev_q;
   logic [7:0]  d_q;
   cam_state_e  state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic        load_seen_q, load_seen_d;
   logic        wr_q, wr_d, wr_load_q, wr_load_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        done_q, done_d, overflow_q, overflow_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic        vs_rise_s, href_fall_s, pack_clr_s, pack_vld_s, word_vld_s;
   logic [15:0] word_data_s, pix_word_s;

   // Camera input register plus one-cycle-delayed copies for edge detection.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         d_q          <= 8'h00;
         vsync_prev_q <= 1'b0;
         href_prev_q  <= 1'b0;
      end else begin
         vsync_q      <= CAM_VSYNC;
         href_q       <= CAM_HREF;
         d_q          <= CAM_D;
         vsync_prev_q <= vsync_q;
         href_prev_q  <= href_q;
      end
   end

   assign vs_rise_s   = vsync_q & ~vsync_prev_q;
   assign href_fall_s = href_prev_q & ~href_q;
   // A VSYNC rise mid-line closes the line as well, so the byte in that cycle is ignored.
   assign pack_clr_s  = (state_q != CAPTURE) | href_fall_s | vs_rise_s;
   assign pack_vld_s  = (state_q == CAPTURE) & href_q & ~vs_rise_s;

   cam_byte_packer u_packer (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .clr      (pack_clr_s),
      .byte_vld (pack_vld_s),
      .byte_in  (d_q),
      .word_vld (word_vld_s),
      .word     (word_data_s)
   );

`ifdef CAM_TEST_PATTERN_EN
   logic       pat_q, pat_d;
   logic [2:0] bar_idx_s;

   // Pattern select is captured while the frame is loading and held for the frame.
   always_comb begin
      if (state_q == LOAD) begin
         pat_d = PATTERN_SEL;
      end else begin
         pat_d = pat_q;
      end
   end

   // Pattern select register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pat_q <= 1'b0;
      end else begin
         pat_q <= pat_d;
      end
   end

   assign bar_idx_s  = 3'(({x_q, 3'b000}) / (XW + 3)'(H_ACTIVE));
   assign pix_word_s = pat_q ? bar_color(bar_idx_s) : word_data_s;
`else
   assign pix_word_s = word_data_s;
`endif

   // Frame FSM next-state, crop counters and output strobes.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      load_seen_d = load_seen_q;
      overflow_d  = overflow_q;
      wr_d        = 1'b0;
      wr_data_d   = wr_data_q;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         IDLE: begin
            load_seen_d = 1'b0;
            if (vs_rise_s && EN) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            x_d         = '0;
            y_d         = '0;
            overflow_d  = 1'b0;
            load_seen_d = 1'b1;
            // load_seen guarantees a two-cycle minimum WR_LOAD pulse.
            if (!vsync_q && load_seen_q) begin
               state_d = CAPTURE;
            end else begin
               state_d = LOAD;
            end
         end
         CAPTURE: begin
            if (vs_rise_s) begin
               done_d      = 1'b1;
               frame_cnt_d = frame_cnt_q + 16'd1;
               x_d         = '0;
               load_seen_d = 1'b0;
               if (EN) begin
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else if (href_fall_s) begin
               x_d = '0;
               if (y_q < Y_MAX) begin
                  y_d = y_q + YW'(1);
               end else begin
                  y_d = y_q;
               end
            end else if (word_vld_s) begin
               if ((x_q < X_MAX) && (y_q < Y_MAX)) begin
                  if (!wr_port.WR_FULL) begin
                     wr_d      = 1'b1;
                     wr_data_d = pix_word_s;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end else begin
                  overflow_d = overflow_q;
               end
               if (x_q < X_MAX) begin
                  x_d = x_q + XW'(1);
               end else begin
                  x_d = x_q;
               end
            end else begin
               x_d = x_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      wr_load_d = (state_d == LOAD);
   end

   // FSM, counters and registered outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         load_seen_q <= 1'b0;
         wr_q        <= 1'b0;
         wr_load_q   <= 1'b0;
         wr_data_q   <= 16'h0000;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         frame_cnt_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         load_seen_q <= load_seen_d;
         wr_q        <= wr_d;
         wr_load_q   <= wr_load_d;
         wr_data_q   <= wr_data_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign wr_port.WR        = wr_q;
   assign wr_port.WR_DATA   = wr_data_q;
   assign wr_port.WR_LOAD   = wr_load_q;
   assign wr_port.WR_ADDR   = BASE_ADDR;
   assign wr_port.WR_LENGTH = 9'(BURST_LEN);
   assign FRAME_DONE        = done_q;
   assign OVERFLOW          = overflow_q;
   assign FRAME_CNT         = frame_cnt_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer using a reduced 8x4 active window.
module tb_cam_frame_writer;

   localparam int H = 8;
   localparam int V = 4;
   localparam logic [21:0] BASE = 22'h0ABCDE;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        EN;
   logic        CAM_VSYNC;
   logic        CAM_HREF;
   logic [7:0]  CAM_D;
   logic        FRAME_DONE;
   logic        OVERFLOW;
   logic [15:0] FRAME_CNT;

   cam_frame_writer_if wr_if ();

   cam_frame_writer #(
      .H_ACTIVE  (H),
      .V_ACTIVE  (V),
      .BASE_ADDR (BASE),
      .BURST_LEN (128)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .EN         (EN),
      .CAM_VSYNC  (CAM_VSYNC),
      .CAM_HREF   (CAM_HREF),
      .CAM_D      (CAM_D),
`ifdef CAM_TEST_PATTERN_EN
      .PATTERN_SEL(1'b0),
`endif
      .wr_port    (wr_if.master),
      .FRAME_DONE (FRAME_DONE),
      .OVERFLOW   (OVERFLOW),
      .FRAME_CNT  (FRAME_CNT)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: collect written words and strobe statistics.
   logic [15:0] got[$];
   int first_wr_cyc = -1;
   int load_hi_n = 0, load_rise_n = 0, load_rise_cyc = 0, load_fall_cyc = 0;
   int fd_n = 0, fd_cyc = 0;
   logic wl_prev = 1'b0;
   always @(negedge CLK) begin
      if (wr_if.WR) begin
         got.push_back(wr_if.WR_DATA);
         if (first_wr_cyc < 0) first_wr_cyc <= cyc;
      end
      if (wr_if.WR_LOAD) load_hi_n <= load_hi_n + 1;
      if (wr_if.WR_LOAD && !wl_prev) begin
         load_rise_n   <= load_rise_n + 1;
         load_rise_cyc <= cyc;
      end
      if (!wr_if.WR_LOAD && wl_prev) load_fall_cyc <= cyc;
      wl_prev <= wr_if.WR_LOAD;
      if (FRAME_DONE) begin
         fd_n   <= fd_n + 1;
         fd_cyc <= cyc;
      end
   end

   int total = 0;
   int bad = 0;
   int bytev = 0;
   int first_lo_cyc = -1;
   int vs_on_cyc = 0, vs_off_cyc = 0;
   int base, snap_hi, snap_rise, snap_fd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int w16(input int a, input int b);
      return ((a & 255) << 8) | (b & 255);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic vs_pulse(input int n);
      @(negedge CLK);
      CAM_VSYNC = 1'b1;
      vs_on_cyc = cyc;
      repeat (n) @(negedge CLK);
      CAM_VSYNC = 1'b0;
      vs_off_cyc = cyc;
      tick(4);
   endtask

   // Drives nb bytes with HREF high; words dlo..dhi of the line see WR_FULL high
   // on the edge where each is registered (lo byte edge + 1).
   task automatic send_line(input int nb, input int dlo, input int dhi);
      for (int i = 0; i < nb + 2; i++) begin
         @(negedge CLK);
         CAM_HREF = (i < nb);
         if (i < nb) begin
            CAM_D = 8'(bytev);
            bytev++;
            if (first_lo_cyc < 0 && i == 1) first_lo_cyc = cyc;
         end
         wr_if.WR_FULL = (i >= 2) && (((i - 2) / 2) >= dlo) && (((i - 2) / 2) <= dhi);
      end
      @(negedge CLK);
      CAM_HREF = 1'b0;
      wr_if.WR_FULL = 1'b0;
      tick(3);
   endtask

   initial begin
      RESET_N = 1'b0; EN = 1'b1; CAM_VSYNC = 1'b0; CAM_HREF = 1'b0; CAM_D = 8'h00;
      wr_if.WR_FULL = 1'b0;
      tick(3);
      chk("rst_wr", 32'(wr_if.WR), 32'd0);
      chk("rst_wr_load", 32'(wr_if.WR_LOAD), 32'd0);
      chk("rst_wr_data", 32'(wr_if.WR_DATA), 32'd0);
      chk("rst_done", 32'(FRAME_DONE), 32'd0);
      chk("rst_ovf", 32'(OVERFLOW), 32'd0);
      chk("rst_cnt", 32'(FRAME_CNT), 32'd0);
      chk("wr_addr", 32'(wr_if.WR_ADDR), 32'(BASE));
      chk("wr_length", 32'(wr_if.WR_LENGTH), 32'd128);
      RESET_N = 1'b1;
      tick(3);

      // Frame 1: 10-cycle VSYNC, then four full lines.
      vs_pulse(10);
      chk("load_rise_delay", 32'(load_rise_cyc - vs_on_cyc), 32'd2);
      chk("load_fall_delay", 32'(load_fall_cyc - vs_off_cyc), 32'd2);
      chk("load_hi_cycles", 32'(load_hi_n), 32'd10);
      chk("no_done_from_idle", 32'(fd_n), 32'd0);
      base = got.size();
      bytev = 0;
      for (int l = 0; l < 4; l++) send_line(16, 1000, -1);
      chk("f1_count", 32'(got.size() - base), 32'd32);
      chk("f1_first", 32'(got[base]), 32'h0001);
      chk("f1_second", 32'(got[base + 1]), 32'h0203);
      for (int k = 0; k < 32 && base + k < got.size(); k++)
         chk("f1_word", 32'(got[base + k]), 32'(w16(2 * k, 2 * k + 1)));
      chk("first_wr_latency", 32'(first_wr_cyc - first_lo_cyc), 32'd2);
      vs_pulse(3);
      chk("f1_done_n", 32'(fd_n), 32'd1);
      chk("f1_cnt", 32'(FRAME_CNT), 32'd1);
      chk("done_with_load", 32'(fd_cyc), 32'(load_rise_cyc));

      // Frame 2: oversize 10-pixel x 5-line frame is cropped to 8 x 4.
      base = got.size();
      bytev = 0;
      for (int l = 0; l < 5; l++) send_line(20, 1000, -1);
      chk("f2_count", 32'(got.size() - base), 32'd32);
      for (int k = 0; k < 32 && base + k < got.size(); k++)
         chk("f2_word", 32'(got[base + k]), 32'(w16(20 * (k / 8) + 2 * (k % 8), 20 * (k / 8) + 2 * (k % 8) + 1)));
      vs_pulse(3);
      chk("f2_cnt", 32'(FRAME_CNT), 32'd2);

      // Frame 3: WR_FULL on words 2..6 of the line.
      base = got.size();
      bytev = 0;
      send_line(16, 2, 6);
      chk("f3_count", 32'(got.size() - base), 32'd3);
      if (got.size() >= base + 3) begin
         chk("f3_w0", 32'(got[base]), 32'h0001);
         chk("f3_w1", 32'(got[base + 1]), 32'h0203);
         chk("f3_w7", 32'(got[base + 2]), 32'h0E0F);
      end
      tick(5);
      chk("ovf_sticky", 32'(OVERFLOW), 32'd1);
      vs_pulse(3);
      chk("ovf_cleared", 32'(OVERFLOW), 32'd0);
      chk("f3_cnt", 32'(FRAME_CNT), 32'd3);

      // Frame 4: 3-byte line leaves a dangling byte that must not leak.
      base = got.size();
      bytev = 0;
      send_line(3, 1000, -1);
      send_line(4, 1000, -1);
      chk("f4_count", 32'(got.size() - base), 32'd3);
      if (got.size() >= base + 3) begin
         chk("f4_w0", 32'(got[base]), 32'h0001);
         chk("f4_w1", 32'(got[base + 1]), 32'h0304);
         chk("f4_w2", 32'(got[base + 2]), 32'h0506);
      end
      EN = 1'b0;
      snap_rise = load_rise_n;
      vs_pulse(3);
      chk("f4_cnt", 32'(FRAME_CNT), 32'd4);
      chk("f4_done_n", 32'(fd_n), 32'd4);
      chk("en0_no_load", 32'(load_rise_n), 32'(snap_rise));

      // EN=0: stays idle, nothing written, count unchanged.
      base = got.size();
      send_line(16, 1000, -1);
      vs_pulse(3);
      send_line(16, 1000, -1);
      chk("idle_no_wr", 32'(got.size() - base), 32'd0);
      chk("idle_no_load", 32'(load_rise_n), 32'(snap_rise));
      chk("idle_cnt", 32'(FRAME_CNT), 32'd4);

      // Reset mid-line aborts; next frame starts from IDLE.
      EN = 1'b1;
      vs_pulse(3);
      chk("pre_rst_load", 32'(load_rise_n), 32'(snap_rise + 1));
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         CAM_HREF = 1'b1;
         CAM_D = 8'(i);
      end
      @(negedge CLK);
      RESET_N = 1'b0;
      @(negedge CLK);
      chk("midrst_wr", 32'(wr_if.WR), 32'd0);
      chk("midrst_cnt", 32'(FRAME_CNT), 32'd0);
      chk("midrst_load", 32'(wr_if.WR_LOAD), 32'd0);
      RESET_N = 1'b1;
      CAM_HREF = 1'b0;
      tick(3);
      base = got.size();
      send_line(16, 1000, -1);
      chk("post_rst_idle", 32'(got.size() - base), 32'd0);
      vs_pulse(3);
      base = got.size();
      bytev = 0;
      send_line(16, 1000, -1);
      chk("post_rst_count", 32'(got.size() - base), 32'd8);
      if (got.size() > base) chk("post_rst_first", 32'(got[base]), 32'h0001);
      vs_pulse(3);
      chk("post_rst_cnt", 32'(FRAME_CNT), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
